// File: rtl/cs_pkg.sv
// Shared constants and read-FSM encoding for the compressed-sensing input path.
// The CS core also takes FRAME_LEN and SYM_W from this package, so the frame
// geometry is defined in one place.
package cs_pkg;

  localparam int FRAME_LEN = 96;
  localparam int SYM_W     = 4;
  localparam int CNT_W     = 8;
  localparam int FCNT_W    = 16;
  localparam int ADDR_W    = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/cs_frame_buffer_if.sv
// Bundle of the upstream sample handshake and the CS-core side signals of
// cs_frame_buffer.
//   slave  : the frame buffer (accepts samples, drives the core side)
//   master : the environment (upstream source plus CS core)
// Signals:
//   in_valid/in_ready/in_data : sample handshake
//   value_counter/end_flag    : index and completion flag from the CS core
//   values/cs_rst_n           : sample and active-low reset to the CS core
//   frame_done/bank_full/frame_cnt : status
interface cs_frame_buffer_if;
  import cs_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SYM_W-1:0]  in_data;
  logic [CNT_W-1:0]  value_counter;
  logic              end_flag;
  logic [SYM_W-1:0]  values;
  logic              cs_rst_n;
  logic              frame_done;
  logic [1:0]        bank_full;
  logic [FCNT_W-1:0] frame_cnt;

  modport slave (
    input  in_valid, in_data, value_counter, end_flag,
    output in_ready, values, cs_rst_n, frame_done, bank_full, frame_cnt
  );

  modport master (
    output in_valid, in_data, value_counter, end_flag,
    input  in_ready, values, cs_rst_n, frame_done, bank_full, frame_cnt
  );

endinterface

// File: rtl/cs_bank_mem.sv
// Two-bank sample store for the ping-pong frame buffer.
// Ports:
//   sys_clk                         : write clock
//   we_i, wr_bank_i, wr_addr_i, wr_data_i : synchronous write port
//   rd_bank_i, rd_addr_i, rd_data_o : asynchronous read port
// Contents are deliberately not reset; a bank is only read once it is full.
module cs_bank_mem import cs_pkg::*; (
  input  logic              sys_clk,
  input  logic              we_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [SYM_W-1:0]  wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [SYM_W-1:0]  rd_data_o
);

  logic [SYM_W-1:0] mem_q [2][FRAME_LEN];

  // Single write port, one sample per accepted handshake
  always_ff @(posedge sys_clk) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/cs_frame_buffer.sv
// Ping-pong frame buffer in front of the compressed-sensing core. One bank
// fills from the upstream stream while the other is read by the core using the
// core's own value_counter; the core's reset is sequenced around each frame.
// Ports:
//   sys_clk   : clock
//   sys_reset : asynchronous, active-low reset
//   bus       : cs_frame_buffer_if.slave (handshake, core side, status)
module cs_frame_buffer import cs_pkg::*; (
  input logic               sys_clk,
  input logic               sys_reset,
  cs_frame_buffer_if.slave  bus
);

  state_t              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic                full_seen_q, full_seen_d;
  logic                cs_rst_n_q, cs_rst_n_d;
  logic                frame_done_q, frame_done_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;

  logic                in_ready;
  logic                accept;
  logic                in_range;
  logic [1:0]          set_full;
  logic [1:0]          clr_full;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SYM_W-1:0]    rd_data;

  assign in_ready = ~bank_full_q[wr_bank_q];
  assign accept   = bus.in_valid & in_ready;
  assign in_range = bus.value_counter < CNT_W'(FRAME_LEN);
  // Out-of-range indices never reach the memory
  assign rd_addr  = in_range ? bus.value_counter[ADDR_W-1:0] : '0;

  cs_bank_mem u_mem (
    .sys_clk   (sys_clk),
    .we_i      (accept),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.in_data),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Writer: advance the pointer, and on the last sample mark the bank full
  // and swap to the other bank in the same edge.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    set_full  = 2'b00;
    if (accept) begin
      if (wr_ptr_q == ADDR_W'(FRAME_LEN - 1)) begin
        set_full[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
        wr_ptr_d            = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read FSM next state. IDLE waits on a registered view of the read bank's
  // full flag, which keeps the core's reset low for at least two cycles
  // between back-to-back frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_seen_q && bank_full_q[rd_bank_q]) state_d = RUN;
      RUN:     if (bus.end_flag || (bus.value_counter == CNT_W'(FRAME_LEN))) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs. cs_rst_n and frame_done are registered from the next
  // state; leaving RELEASE frees the bank and swaps the read side.
  always_comb begin
    cs_rst_n_d   = (state_d == RUN);
    frame_done_d = (state_d == RELEASE);
    full_seen_d  = (state_q == IDLE) && bank_full_q[rd_bank_q];
    rd_bank_d    = rd_bank_q;
    frame_cnt_d  = frame_cnt_q;
    clr_full     = 2'b00;
    if (state_q == RELEASE) begin
      clr_full[rd_bank_q] = 1'b1;
      rd_bank_d           = ~rd_bank_q;
      frame_cnt_d         = frame_cnt_q + 1'b1;
    end
    // Set and clear always target different banks, so both can apply at once
    bank_full_d = (bank_full_q | set_full) & ~clr_full;
  end

  // Pointer, bank and status registers
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      full_seen_q  <= 1'b0;
      cs_rst_n_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      full_seen_q  <= full_seen_d;
      cs_rst_n_q   <= cs_rst_n_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.values     = ((state_q == RUN) && in_range) ? rd_data : '0;
  assign bus.cs_rst_n   = cs_rst_n_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bank_full  = bank_full_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule
